// File: rtl/fill_station_ctrl.sv
// -----------------------------------------------------------------------------
// fill_station_ctrl
//
// Filling-stage controller sitting directly upstream of the sealing FSM.
// A bottle is carried on the conveyor to the fill position and filled through
// the fill valve until the level sensor trips. It then waits a fixed settling
// time before the quality sensor is read. Good bottles are offered to the
// sealing stage with backpressure. Bad bottles are pushed off by the discard
// actuator. A fill that never reaches level raises a latched alarm, and only
// the operator can clear it.
//
// Parameters
//   FILL_TIMEOUT : maximum FILL cycles without level before ALARM (>= 2)
//   CQ_WAIT      : CHECK cycles before sensor_cq is sampled (>= 1)
//
// Optional feature macro: FILL_STATS_EN
//   defined   : disc_count counts discarded bottles, including timed-out fills
//   undefined : disc_count is tied to zero and its counter is not built
//
// Ports
//   clk             in   system clock, all state on the rising edge
//   reset           in   synchronous, active-high
//   start           in   run enable (level); 0 stops the line
//   garrafa         in   bottle present at the fill position
//   sensor_de_nivel in   fill level reached
//   sensor_cq       in   quality check result, 1 = pass
//   ve_ready        in   sealing stage can accept a bottle
//   alarm_ack       in   operator alarm clear
//   motor           out  conveyor drive
//   ev              out  fill valve open
//   pos_ve          out  bottle offered to the sealing stage
//   descarte        out  discard actuator
//   alarme          out  fill-timeout alarm
//   ok_count  [7:0] out  bottles handed to sealing, mod 256
//   disc_count[7:0] out  bottles discarded, mod 256
// -----------------------------------------------------------------------------
module fill_station_ctrl #(
    parameter int FILL_TIMEOUT = 200,
    parameter int CQ_WAIT      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       garrafa,
    input  logic       sensor_de_nivel,
    input  logic       sensor_cq,
    input  logic       ve_ready,
    input  logic       alarm_ack,
    output logic       motor,
    output logic       ev,
    output logic       pos_ve,
    output logic       descarte,
    output logic       alarme,
    output logic [7:0] ok_count,
    output logic [7:0] disc_count
);

    // One timer serves both FILL and CHECK, so it is sized for the longer one.
    localparam int TIMER_MAX = (FILL_TIMEOUT > CQ_WAIT) ? FILL_TIMEOUT : CQ_WAIT;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] FILL_LAST = TIMER_W'(FILL_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] CQ_LAST   = TIMER_W'(CQ_WAIT - 1);

    generate
        if (FILL_TIMEOUT < 2) begin : g_bad_fill_timeout
            $error("fill_station_ctrl: FILL_TIMEOUT must be >= 2");
        end
        if (CQ_WAIT < 1) begin : g_bad_cq_wait
            $error("fill_station_ctrl: CQ_WAIT must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        TRANSPORT,
        FILL,
        CHECK,
        HANDOFF,
        DISCARD,
        ALARM
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_next;
    logic                 ok_inc;

    // -------------------------------------------------------------------------
    // State and timer registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, timer update and Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        timer_next = timer;
        motor      = 1'b0;
        ev         = 1'b0;
        pos_ve     = 1'b0;
        descarte   = 1'b0;
        alarme     = 1'b0;

        if (state == ALARM) begin
            // The alarm holds regardless of start; only the operator releases it.
            if (alarm_ack) begin
                state_next = IDLE;
            end
        end else if (!start) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = TRANSPORT;
                end
                TRANSPORT: begin
                    if (garrafa) begin
                        state_next = FILL;
                    end
                end
                FILL: begin
                    // Bottle removal beats everything; level beats the timeout
                    // when both land on the same cycle.
                    if (!garrafa) begin
                        state_next = TRANSPORT;
                    end else if (sensor_de_nivel) begin
                        state_next = CHECK;
                    end else if (timer == FILL_LAST) begin
                        state_next = ALARM;
                    end
                end
                CHECK: begin
                    if (!garrafa) begin
                        state_next = TRANSPORT;
                    end else if (timer == CQ_LAST) begin
                        state_next = sensor_cq ? HANDOFF : DISCARD;
                    end
                end
                HANDOFF: begin
                    // The bottle only leaves while the conveyor is allowed to run.
                    if (ve_ready && !garrafa) begin
                        state_next = TRANSPORT;
                    end
                end
                DISCARD: begin
                    if (!garrafa) begin
                        state_next = TRANSPORT;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Timer restarts on every state change, so each timed state starts at 0.
        if (state_next != state) begin
            timer_next = '0;
        end else if (state == FILL || state == CHECK) begin
            timer_next = timer + TIMER_W'(1);
        end

        unique case (state)
            TRANSPORT: begin
                motor = 1'b1;
            end
            FILL: begin
                ev = 1'b1;
            end
            HANDOFF: begin
                pos_ve = 1'b1;
                motor  = ve_ready;
            end
            DISCARD: begin
                descarte = 1'b1;
                motor    = 1'b1;
            end
            ALARM: begin
                alarme = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Good-bottle counter
    // -------------------------------------------------------------------------
    assign ok_inc = (state == HANDOFF) && (state_next == TRANSPORT);

    always_ff @(posedge clk) begin
        if (reset) begin
            ok_count <= 8'd0;
        end else if (ok_inc) begin
            ok_count <= ok_count + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Discard counter
    // -------------------------------------------------------------------------
`ifdef FILL_STATS_EN
    logic disc_inc;

    // A timed-out bottle is also lost to the line, so ALARM entry counts.
    assign disc_inc = ((state == DISCARD) && (state_next == TRANSPORT)) ||
                      ((state == FILL)    && (state_next == ALARM));

    always_ff @(posedge clk) begin
        if (reset) begin
            disc_count <= 8'd0;
        end else if (disc_inc) begin
            disc_count <= disc_count + 8'd1;
        end
    end
`else
    assign disc_count = 8'd0;
`endif

endmodule

// File: tb/tb_fill_station_ctrl.sv
module tb_fill_station_ctrl;

    localparam int FILL_TIMEOUT = 200;
    localparam int CQ_WAIT      = 4;
`ifdef FILL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk             = 1'b0;
    logic       reset           = 1'b1;
    logic       start           = 1'b0;
    logic       garrafa         = 1'b0;
    logic       sensor_de_nivel = 1'b0;
    logic       sensor_cq       = 1'b0;
    logic       ve_ready        = 1'b0;
    logic       alarm_ack       = 1'b0;
    logic       motor, ev, pos_ve, descarte, alarme;
    logic [7:0] ok_count, disc_count;

    fill_station_ctrl #(
        .FILL_TIMEOUT (FILL_TIMEOUT),
        .CQ_WAIT      (CQ_WAIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .garrafa         (garrafa),
        .sensor_de_nivel (sensor_de_nivel),
        .sensor_cq       (sensor_cq),
        .ve_ready        (ve_ready),
        .alarm_ack       (alarm_ack),
        .motor           (motor),
        .ev              (ev),
        .pos_ve          (pos_ve),
        .descarte        (descarte),
        .alarme          (alarme),
        .ok_count        (ok_count),
        .disc_count      (disc_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       motor;
        logic       ev;
        logic       pos_ve;
        logic       descarte;
        logic       alarme;
        logic [7:0] ok;
        logic [7:0] disc;
    } obs_t;

    obs_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   ev_run  = 0;
    int   ev_last = 0;

    // ---------------- reference model ----------------
    // Line activity: stopped, moving, filling, checking, offering, rejecting, faulted.
    localparam int P_STOPPED  = 0;
    localparam int P_MOVING   = 1;
    localparam int P_FILLING  = 2;
    localparam int P_CHECKING = 3;
    localparam int P_OFFER    = 4;
    localparam int P_REJECT   = 5;
    localparam int P_FAULT    = 6;

    int phase   = P_STOPPED;
    int elapsed = 0;   // cycles already spent in the current filling/checking phase
    int m_ok    = 0;
    int m_disc  = 0;

    task automatic model_step();
        int nxt;
        nxt = phase;
        if (reset) begin
            phase = P_STOPPED; elapsed = 0; m_ok = 0; m_disc = 0;
            return;
        end
        if (phase == P_FAULT) begin
            if (alarm_ack) nxt = P_STOPPED;
        end else if (!start) begin
            nxt = P_STOPPED;
        end else if (phase == P_STOPPED) begin
            nxt = P_MOVING;
        end else if (phase == P_MOVING) begin
            if (garrafa) nxt = P_FILLING;
        end else if (phase == P_FILLING) begin
            if (!garrafa)                       nxt = P_MOVING;
            else if (sensor_de_nivel)           nxt = P_CHECKING;
            else if (elapsed + 1 == FILL_TIMEOUT) begin
                nxt = P_FAULT;
                if (STATS) m_disc = (m_disc + 1) % 256;
            end
        end else if (phase == P_CHECKING) begin
            if (!garrafa)                  nxt = P_MOVING;
            else if (elapsed + 1 == CQ_WAIT) nxt = sensor_cq ? P_OFFER : P_REJECT;
        end else if (phase == P_OFFER) begin
            if (ve_ready && !garrafa) begin
                nxt  = P_MOVING;
                m_ok = (m_ok + 1) % 256;
            end
        end else if (phase == P_REJECT) begin
            if (!garrafa) begin
                nxt = P_MOVING;
                if (STATS) m_disc = (m_disc + 1) % 256;
            end
        end
        elapsed = (nxt == phase) ? elapsed + 1 : 0;
        phase   = nxt;
    endtask

    function automatic obs_t model_view();
        obs_t o;
        o.motor    = (phase == P_MOVING) || (phase == P_REJECT) ||
                     (phase == P_OFFER && ve_ready);
        o.ev       = (phase == P_FILLING);
        o.pos_ve   = (phase == P_OFFER);
        o.descarte = (phase == P_REJECT);
        o.alarme   = (phase == P_FAULT);
        o.ok       = 8'(m_ok);
        o.disc     = 8'(m_disc);
        return o;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit r, input bit s, input bit g, input bit l,
                         input bit q, input bit rd, input bit a);
        @(negedge clk);
        reset = r; start = s; garrafa = g; sensor_de_nivel = l;
        sensor_cq = q; ve_ready = rd; alarm_ack = a;
        model_step();
        exp_q.push_back(model_view());
    endtask

    // One bottle: arrives, fills for fill_len cycles, checks, then waits
    // 'stall' cycles with the sealing stage not ready before leaving.
    task automatic bottle(input int fill_len, input bit cq, input int stall);
        drive(0, 1, 0, 0, 0, 1, 0);
        drive(0, 1, 1, 0, 0, 1, 0);
        repeat (fill_len - 1) drive(0, 1, 1, 0, 0, 1, 0);
        drive(0, 1, 1, 1, cq, 1, 0);
        repeat (CQ_WAIT) drive(0, 1, 1, 0, cq, 1, 0);
        repeat (stall) drive(0, 1, 1, 0, cq, 0, 0);
        drive(0, 1, 0, 0, cq, 1, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            a = '{motor, ev, pos_ve, descarte, alarme, ok_count, disc_count};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                nvec++;
                if (a !== e) begin
                    nerr++;
                    $display("FAIL outputs t=%0t: got motor=%b ev=%b pos_ve=%b descarte=%b alarme=%b ok=%0d disc=%0d, want motor=%b ev=%b pos_ve=%b descarte=%b alarme=%b ok=%0d disc=%0d",
                             $time, a.motor, a.ev, a.pos_ve, a.descarte, a.alarme, a.ok, a.disc,
                             e.motor, e.ev, e.pos_ve, e.descarte, e.alarme, e.ok, e.disc);
                end
            end
            if (ev === 1'b1) begin
                ev_run++;
            end else if (ev_run > 0) begin
                ev_last = ev_run;
                ev_run  = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) drive(1, 0, 0, 0, 0, 0, 0);

        // Pass path with a 10-cycle fill.
        bottle(10, 1'b1, 0);
        settle();
        check_val("pass_ev_cycles", ev_last, 10);
        check_val("pass_ok_count", int'(ok_count), 1);

        // Fail path.
        drive(1, 0, 0, 0, 0, 0, 0);
        bottle(10, 1'b0, 0);
        settle();
        check_val("fail_ok_count", int'(ok_count), 0);
        check_val("fail_disc_count", int'(disc_count), STATS ? 1 : 0);

        // Fill timeout, then start toggling while the alarm holds.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 0);
        repeat (FILL_TIMEOUT + 5) drive(0, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) drive(0, i % 2, 1, 0, 0, 1, 0);
        settle();
        check_val("timeout_ev_cycles", ev_last, FILL_TIMEOUT);
        check_val("alarm_held", int'(alarme), 1);
        drive(0, 0, 1, 0, 0, 0, 1);
        settle();
        check_val("alarm_cleared", int'(alarme), 0);

        // Backpressure: 20 cycles with the sealing stage busy.
        bottle(5, 1'b1, 20);

        // start dropped mid-fill.
        drive(0, 1, 0, 0, 0, 1, 0);
        drive(0, 1, 1, 0, 0, 1, 0);
        repeat (3) drive(0, 1, 1, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0, 1, 0);

        // Reset while offering a bottle.
        drive(0, 1, 0, 0, 0, 1, 0);
        drive(0, 1, 1, 0, 0, 1, 0);
        drive(0, 1, 1, 1, 1, 1, 0);
        repeat (CQ_WAIT) drive(0, 1, 1, 0, 1, 1, 0);
        drive(0, 1, 1, 0, 1, 0, 0);
        drive(1, 1, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Counter wrap over 256 good bottles.
        for (int i = 0; i < 256; i++) bottle(1 + (i % 3), 1'b1, 0);
        settle();
        check_val("ok_wrap", int'(ok_count), 0);

        // Level on the very cycle the timeout would fire.
        bottle(FILL_TIMEOUT, 1'b1, 0);
        settle();
        check_val("coincident_no_alarm", int'(alarme), 0);
        check_val("coincident_ok_count", int'(ok_count), 1);

        // Randomized bottles.
        for (int i = 0; i < 30; i++)
            bottle(int'($urandom_range(40, 1)), 1'($urandom_range(1, 0)),
                   int'($urandom_range(5, 0)));

        // Fully random input soup.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(63, 0) == 0), ($urandom_range(7, 0) != 0),
                  1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  ($urandom_range(7, 0) == 0));
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        settle();
        check_val("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
